vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
- Downstream stage of the coin accumulator; consumes its 5-bit running `total`.
- On a product selection it compares `total` against the item price. If funds suffice, it pulses a dispense command, returns change one coin at a time over a valid/ready handshake, then pulses a clear back to the accumulator.
- Also handles cancel/refund.
- Sits between the accumulator and the product/change dispenser drivers.

Parameters:
- PRICE0, 5, price of item 0 in coin units (1..31)
- PRICE1, 8, price of item 1
- PRICE2, 12, price of item 2
- PRICE3, 20, price of item 3

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- total  in  5  accumulated money from accumulator
- sel_valid  in  1  selection request
- sel  in  2  item index
- cancel  in  1  refund request, honoured in IDLE only
- change_ready  in  1  change dispenser accepts current coin
- coin_accept  out  1  high only in IDLE; accumulator/coin front-end must gate coin_valid with it
- dispense  out  1  one-cycle pulse, product release
- item  out  2  item being dispensed, valid with dispense
- deny  out  1  one-cycle pulse, insufficient funds
- change_valid  out  1  change coin offered
- change_coin  out  4  denomination offered (10, 5 or 1)
- acc_clear  out  1  one-cycle pulse, zero the accumulator

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low, named `rst_n`.
- Reset: when rst_n=0 at a clock edge:
  - state goes to IDLE; remaining=0; sel_q=0.
  - All outputs go to 0, except coin_accept=1.
  - Applies from any state, including mid-CHANGE; the in-flight coin is dropped and no acc_clear is issued.
- Outputs are Moore/registered from state; no combinational input-to-output paths.
- State IDLE (coin_accept=1):
  - If sel_valid=1: latch sel_q=sel, go to CHECK. sel_valid has priority over cancel.
  - Else if cancel=1 and total!=0: remaining=total, go to CHANGE (refund, no dispense).
  - Cancel with total=0 is ignored.
- State CHECK: price = PRICEn indexed by sel_q; total is sampled this cycle.
  - If total >= price: remaining = total - price (5-bit, cannot underflow), go to DISPENSE.
  - Else: go to DENY.
- State DENY: deny=1 for one cycle, then IDLE. The accumulator is not cleared; money is retained.
- State DISPENSE: dispense=1, item=sel_q for exactly one cycle.
  - Next state is CHANGE if remaining!=0, else CLEAR.
- State CHANGE: change_valid=1; change_coin is the greedy choice:
  - 10 if remaining>=10,
  - else 5 if remaining>=5,
  - else 1.
- CHANGE handshake:
  - change_coin and change_valid stay stable until change_ready=1.
  - On a cycle with change_valid & change_ready: remaining -= change_coin.
  - If the new remaining is 0, go to CLEAR; else stay in CHANGE and offer the next coin the following cycle.
  - One coin per accepted handshake; back-to-back acceptance is allowed.
- State CLEAR: acc_clear=1 for one cycle, then IDLE.
- Latency with total sufficient, sel accepted at edge k:
  - CHECK during cycle k+1.
  - dispense during k+2.
  - First change_valid, or acc_clear, during k+3.
- Coins arriving while coin_accept=0 are the upstream's responsibility and are not counted here.
- Out-of-range prices (0 or >31) are illegal parameter values; an elaboration-time check is required.

Optional Feature:
- Macro: VEND_SALES_COUNT_EN
- Defined: adds output sales_count[7:0], reset to 0.
  - Increments by 1 in every DISPENSE cycle.
  - Saturates at 255; never wraps.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, CHECK, DENY, DISPENSE, CHANGE, CLEAR)
  - denomination constants COIN_10=10, COIN_5=5, COIN_1=1
  - MONEY_W=5, COIN_W=4
- Sub-module change_picker: combinational greedy denomination selector, remaining[4:0] -> coin[3:0]. Reusable by a future refund-only path.

Test Plan:
- total=20, sel=2 (price 12), change_ready=1 -> dispense with item=2; change coins 5,1,1,1 on consecutive cycles; then acc_clear pulse.
- total=5, sel=0 -> dispense, no change_valid, acc_clear on the cycle after dispense.
- total=6, sel=3 (price 20) -> deny pulse, no dispense/acc_clear, back in IDLE with coin_accept=1.
- total=17, cancel=1 in IDLE -> no dispense; change 10,5,1,1; acc_clear; cancel with total=0 produces nothing.
- total=31, sel=1, change_ready held 0 for 3 cycles -> change_coin=10 stable and valid throughout; sequence 10,10,1,1,1 after release.
- rst_n=0 during CHANGE -> next cycle IDLE, all outputs 0, coin_accept=1, no acc_clear; with VEND_SALES_COUNT_EN, 256 sales -> sales_count=255.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice.
package vend_pkg;

    localparam int unsigned MONEY_W = 5;
    localparam int unsigned COIN_W  = 4;

    localparam logic [COIN_W-1:0] COIN_10 = COIN_W'(10);
    localparam logic [COIN_W-1:0] COIN_5  = COIN_W'(5);
    localparam logic [COIN_W-1:0] COIN_1  = COIN_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        DENY     = 3'd2,
        DISPENSE = 3'd3,
        CHANGE   = 3'd4,
        CLEAR    = 3'd5
    } vend_state_e;

endpackage

// File: rtl/change_picker.sv
// Greedy change denomination selector: largest coin not exceeding remaining.
module change_picker
    import vend_pkg::*;
(
    input  logic [MONEY_W-1:0] remaining,
    output logic [COIN_W-1:0]  coin_c
);

    // Pick 10, then 5, else 1.
    always_comb begin
        coin_c = COIN_1;
        if (remaining >= MONEY_W'(10)) begin
            coin_c = COIN_10;
        end else if (remaining >= MONEY_W'(5)) begin
            coin_c = COIN_5;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: price check, dispense, coin-by-coin change, refund.
// Optional feature macro: VEND_SALES_COUNT_EN adds a saturating sales_count output.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE0 = 5,
    parameter int unsigned PRICE1 = 8,
    parameter int unsigned PRICE2 = 12,
    parameter int unsigned PRICE3 = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MONEY_W-1:0] total,
    input  logic               sel_valid,
    input  logic [1:0]         sel,
    input  logic               cancel,
    input  logic               change_ready,
    output logic               coin_accept,
    output logic               dispense,
    output logic [1:0]         item,
    output logic               deny,
    output logic               change_valid,
    output logic [COIN_W-1:0]  change_coin,
    output logic               acc_clear
`ifdef VEND_SALES_COUNT_EN
    ,
    output logic [7:0]         sales_count
`endif
);

    // Reject prices that cannot be represented or make no sense.
    if (PRICE0 < 1 || PRICE0 > 31) begin : g_bad_price0
        $error("vend_controller: PRICE0 out of range 1..31");
    end
    if (PRICE1 < 1 || PRICE1 > 31) begin : g_bad_price1
        $error("vend_controller: PRICE1 out of range 1..31");
    end
    if (PRICE2 < 1 || PRICE2 > 31) begin : g_bad_price2
        $error("vend_controller: PRICE2 out of range 1..31");
    end
    if (PRICE3 < 1 || PRICE3 > 31) begin : g_bad_price3
        $error("vend_controller: PRICE3 out of range 1..31");
    end

    vend_state_e        state;
    logic [MONEY_W-1:0] remaining;
    logic [1:0]         sel_q;
    logic [MONEY_W-1:0] price_c;
    logic [MONEY_W-1:0] rem_d_c;
    logic [COIN_W-1:0]  pick_c;

    // Price lookup for the latched selection.
    always_comb begin
        price_c = MONEY_W'(PRICE0);
        case (sel_q)
            2'd0:    price_c = MONEY_W'(PRICE0);
            2'd1:    price_c = MONEY_W'(PRICE1);
            2'd2:    price_c = MONEY_W'(PRICE2);
            default: price_c = MONEY_W'(PRICE3);
        endcase
    end

    // Next value of the change balance; the picker sees it so the coin register tracks it.
    always_comb begin
        rem_d_c = remaining;
        case (state)
            IDLE: begin
                if (!sel_valid && cancel && (total != '0)) begin
                    rem_d_c = total;
                end
            end
            CHECK: begin
                if (total >= price_c) begin
                    rem_d_c = total - price_c;
                end
            end
            CHANGE: begin
                if (change_valid && change_ready) begin
                    rem_d_c = remaining - MONEY_W'(change_coin);
                end
            end
            default: rem_d_c = remaining;
        endcase
    end

    change_picker u_change_picker (
        .remaining (rem_d_c),
        .coin_c    (pick_c)
    );

    // Controller FSM with registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            sel_q        <= '0;
            coin_accept  <= 1'b1;
            dispense     <= 1'b0;
            item         <= '0;
            deny         <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            acc_clear    <= 1'b0;
        end else begin
            remaining    <= rem_d_c;
            coin_accept  <= 1'b0;
            dispense     <= 1'b0;
            item         <= '0;
            deny         <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            acc_clear    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        sel_q <= sel;
                        state <= CHECK;
                    end else if (cancel && (total != '0)) begin
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_coin  <= pick_c;
                    end else begin
                        coin_accept <= 1'b1;
                    end
                end
                CHECK: begin
                    if (total >= price_c) begin
                        state    <= DISPENSE;
                        dispense <= 1'b1;
                        item     <= sel_q;
                    end else begin
                        state <= DENY;
                        deny  <= 1'b1;
                    end
                end
                DENY: begin
                    state       <= IDLE;
                    coin_accept <= 1'b1;
                end
                DISPENSE: begin
                    if (remaining != '0) begin
                        state        <= CHANGE;
                        change_valid <= 1'b1;
                        change_coin  <= pick_c;
                    end else begin
                        state     <= CLEAR;
                        acc_clear <= 1'b1;
                    end
                end
                CHANGE: begin
                    if (change_ready && (rem_d_c == '0)) begin
                        state     <= CLEAR;
                        acc_clear <= 1'b1;
                    end else begin
                        change_valid <= 1'b1;
                        change_coin  <= pick_c;
                    end
                end
                CLEAR: begin
                    state       <= IDLE;
                    coin_accept <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    coin_accept <= 1'b1;
                end
            endcase
        end
    end

`ifdef VEND_SALES_COUNT_EN
    // Saturating count of dispensed products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sales_count <= '0;
        end else if ((state == DISPENSE) && (sales_count != 8'hFF)) begin
            sales_count <= sales_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller.
module tb_vend_controller;

    logic       clk;
    logic       rst_n;
    logic [4:0] total;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       change_ready;
    logic       coin_accept;
    logic       dispense;
    logic [1:0] item;
    logic       deny;
    logic       change_valid;
    logic [3:0] change_coin;
    logic       acc_clear;
`ifdef VEND_SALES_COUNT_EN
    logic [7:0] sales_count;
`endif

    int checks = 0;
    int errors = 0;

    vend_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .total        (total),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .change_ready (change_ready),
        .coin_accept  (coin_accept),
        .dispense     (dispense),
        .item         (item),
        .deny         (deny),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .acc_clear    (acc_clear)
`ifdef VEND_SALES_COUNT_EN
        ,
        .sales_count  (sales_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output vector: {coin_accept, dispense, item, deny, change_valid, change_coin, acc_clear}.
    function automatic logic [10:0] mk(input bit ca, input bit d, input logic [1:0] it,
                                       input bit dn, input bit cv, input logic [3:0] cc,
                                       input bit cl);
        return {ca, d, it, dn, cv, cc, cl};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and compare the full output vector.
    task automatic expect_cycle(input string tag, input logic [10:0] exp);
        @(negedge clk);
        check_eq(tag, 32'({coin_accept, dispense, item, deny, change_valid, change_coin, acc_clear}),
                 32'(exp));
    endtask

    localparam logic [10:0] V_IDLE = 11'b1_0_00_0_0_0000_0;
    localparam logic [10:0] V_BUSY = 11'b0_0_00_0_0_0000_0;
    localparam logic [10:0] V_CLR  = 11'b0_0_00_0_0_0000_1;

    initial begin
        rst_n = 1'b0; total = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0; change_ready = 1'b1;
        @(negedge clk);
        expect_cycle("reset_idle", V_IDLE);
`ifdef VEND_SALES_COUNT_EN
        check_eq("reset_sales", 32'(sales_count), 32'd0);
`endif
        rst_n = 1'b1;
        expect_cycle("idle_after_reset", V_IDLE);

        // total 20, item 2 (price 12): change 8 = 5,1,1,1
        total = 5'd20; sel = 2'd2; sel_valid = 1'b1; change_ready = 1'b1;
        expect_cycle("t1_check", V_BUSY);
        sel_valid = 1'b0;
        expect_cycle("t1_dispense", mk(0, 1, 2'd2, 0, 0, 4'd0, 0));
        expect_cycle("t1_coin5", mk(0, 0, 2'd0, 0, 1, 4'd5, 0));
        expect_cycle("t1_coin1a", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t1_coin1b", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t1_coin1c", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t1_clear", V_CLR);
        total = '0;
        expect_cycle("t1_idle", V_IDLE);

        // total 5, item 0 exact; cancel asserted together loses to sel_valid
        total = 5'd5; sel = 2'd0; sel_valid = 1'b1; cancel = 1'b1;
        expect_cycle("t2_check", V_BUSY);
        sel_valid = 1'b0; cancel = 1'b0;
        expect_cycle("t2_dispense", mk(0, 1, 2'd0, 0, 0, 4'd0, 0));
        expect_cycle("t2_clear", V_CLR);
        total = '0;
        expect_cycle("t2_idle", V_IDLE);

        // total 6, item 3 (price 20): deny, money kept
        total = 5'd6; sel = 2'd3; sel_valid = 1'b1;
        expect_cycle("t3_check", V_BUSY);
        sel_valid = 1'b0;
        expect_cycle("t3_deny", mk(0, 0, 2'd0, 1, 0, 4'd0, 0));
        expect_cycle("t3_idle", V_IDLE);
        expect_cycle("t3_idle2", V_IDLE);

        // refund of 17: 10,5,1,1
        total = 5'd17; cancel = 1'b1;
        expect_cycle("t4_coin10", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        cancel = 1'b0;
        expect_cycle("t4_coin5", mk(0, 0, 2'd0, 0, 1, 4'd5, 0));
        expect_cycle("t4_coin1a", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t4_coin1b", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t4_clear", V_CLR);
        total = '0; cancel = 1'b1;
        expect_cycle("t4_idle", V_IDLE);
        expect_cycle("t4_cancel0_a", V_IDLE);
        expect_cycle("t4_cancel0_b", V_IDLE);
        cancel = 1'b0;

        // total 31, item 1 (price 8): change 23 with dispenser stalled 3 cycles
        total = 5'd31; sel = 2'd1; sel_valid = 1'b1; change_ready = 1'b0;
        expect_cycle("t5_check", V_BUSY);
        sel_valid = 1'b0;
        expect_cycle("t5_dispense", mk(0, 1, 2'd1, 0, 0, 4'd0, 0));
        expect_cycle("t5_hold1", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        expect_cycle("t5_hold2", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        expect_cycle("t5_hold3", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        change_ready = 1'b1;
        expect_cycle("t5_coin10b", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        expect_cycle("t5_coin1a", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t5_coin1b", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t5_coin1c", mk(0, 0, 2'd0, 0, 1, 4'd1, 0));
        expect_cycle("t5_clear", V_CLR);
        total = '0;
        expect_cycle("t5_idle", V_IDLE);

        // reset while change is pending
        total = 5'd20; sel = 2'd0; sel_valid = 1'b1; change_ready = 1'b0;
        expect_cycle("t6_check", V_BUSY);
        sel_valid = 1'b0;
        expect_cycle("t6_dispense", mk(0, 1, 2'd0, 0, 0, 4'd0, 0));
        expect_cycle("t6_coin10", mk(0, 0, 2'd0, 0, 1, 4'd10, 0));
        rst_n = 1'b0;
        expect_cycle("t6_reset", V_IDLE);
        rst_n = 1'b1; change_ready = 1'b1;
        expect_cycle("t6_no_clear", V_IDLE);
        expect_cycle("t6_still_idle", V_IDLE);

        // after reset the old balance must not leak into the next sale
        total = 5'd5; sel = 2'd0; sel_valid = 1'b1;
        expect_cycle("t7_check", V_BUSY);
        sel_valid = 1'b0;
        expect_cycle("t7_dispense", mk(0, 1, 2'd0, 0, 0, 4'd0, 0));
        expect_cycle("t7_clear", V_CLR);
        total = '0;
        expect_cycle("t7_idle", V_IDLE);

`ifdef VEND_SALES_COUNT_EN
        // 256 exact-price sales saturate the counter at 255
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 256; n++) begin
            total = 5'd5; sel = 2'd0; sel_valid = 1'b1;
            @(negedge clk);
            sel_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            total = '0;
            @(negedge clk);
            if (n == 0) check_eq("sales_one", 32'(sales_count), 32'd1);
        end
        check_eq("sales_sat", 32'(sales_count), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
